// File: rtl/counter_pkg.sv
// Shared constants and the modulus legality check for the modulo counter family.
package counter_pkg;

  localparam bit DIR_UP   = 1'b1;
  localparam bit DIR_DOWN = 1'b0;

  // Legal iff 2 <= modulus <= 2**width; width bounded so the shift stays in 64 bits.
  function automatic bit modulus_ok(input int unsigned width, input longint unsigned modulus);
    return (width > 0) && (width < 63) && (modulus >= 64'd2) && (modulus <= (64'd1 << width));
  endfunction

endpackage

// File: rtl/dff_bank.sv
// WIDTH-wide D register with asynchronous active-low reset to zero.
module dff_bank #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) q <= '0;
    else      q <= d;
  end

endmodule

// File: rtl/mod_counter.sv
// Cascadable up/down modulo-MODULUS counter with clear, saturating load and wrap pulse.
// Optional registered compare flag enabled by defining MOD_COUNTER_MATCH_EN.
module mod_counter
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MODULUS = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap,
  input  logic [WIDTH-1:0] cmp_val,
  output logic             match
);

  localparam logic [WIDTH-1:0] MAX_Q      = WIDTH'(MODULUS - 1);
  localparam bit               FULL_RANGE = (64'(MODULUS) == (64'd1 << WIDTH));

  if (!modulus_ok(WIDTH, 64'(MODULUS))) begin : g_bad_modulus
    $error("mod_counter: MODULUS must lie in 2..2**WIDTH");
  end

  logic [WIDTH-1:0] q_nxt;
  logic             wrap_nxt;
  logic             at_max;
  logic             at_zero;

  assign at_max  = (q == MAX_Q);
  assign at_zero = (q == '0);

  // Zero-latency carry-out so a downstream stage can step on the same edge.
  assign tc = en && ((up_dn == DIR_UP) ? at_max : at_zero);

  // Next count: clr > load > en > hold.
  always_comb begin
    q_nxt    = q;
    wrap_nxt = 1'b0;
    if (clr) begin
      q_nxt = '0;
    end else if (load) begin
      q_nxt = (d > MAX_Q) ? MAX_Q : d;
    end else if (en) begin
      wrap_nxt = tc;
      if (up_dn == DIR_UP) begin
        if (FULL_RANGE) q_nxt = q + WIDTH'(1);
        else            q_nxt = at_max ? '0 : q + WIDTH'(1);
      end else begin
        q_nxt = at_zero ? MAX_Q : q - WIDTH'(1);
      end
    end
  end

  dff_bank #(.WIDTH(WIDTH)) u_q_reg (
    .clk (clk),
    .rst (rst),
    .d   (q_nxt),
    .q   (q)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) wrap <= 1'b0;
    else      wrap <= wrap_nxt;
  end

`ifdef MOD_COUNTER_MATCH_EN
  // Compare the current count; the flag therefore trails q by one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) match <= 1'b0;
    else      match <= (q == cmp_val);
  end
`else
  logic unused_cmp_val;
  assign unused_cmp_val = ^cmp_val;
  assign match          = 1'b0;
`endif

endmodule

// File: tb/tb_mod_counter.sv
// Directed self-checking bench for mod_counter: single instance plus a two-stage cascade.
module tb_mod_counter;

`ifdef MOD_COUNTER_MATCH_EN
  localparam bit MATCH_ON = 1'b1;
`else
  localparam bit MATCH_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       en, up_dn, clr, load;
  logic [3:0] d, cmp_val;
  logic [3:0] q;
  logic       tc, wrap, match;

  logic       cen;
  logic [3:0] q_lo, q_hi;
  logic       tc_lo, tc_hi, wrap_lo, wrap_hi, match_lo, match_hi;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mod_counter #(.WIDTH(4), .MODULUS(10)) dut (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
    .d(d), .q(q), .tc(tc), .wrap(wrap), .cmp_val(cmp_val), .match(match)
  );

  mod_counter #(.WIDTH(4), .MODULUS(10)) u_lo (
    .clk(clk), .rst(rst), .en(cen), .up_dn(1'b1), .clr(1'b0), .load(1'b0),
    .d(4'd0), .q(q_lo), .tc(tc_lo), .wrap(wrap_lo), .cmp_val(4'd0), .match(match_lo)
  );

  mod_counter #(.WIDTH(4), .MODULUS(10)) u_hi (
    .clk(clk), .rst(rst), .en(tc_lo), .up_dn(1'b1), .clr(1'b0), .load(1'b0),
    .d(4'd0), .q(q_hi), .tc(tc_hi), .wrap(wrap_hi), .cmp_val(4'd0), .match(match_hi)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle at the falling edge for sampling/driving.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  int exp_q [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
  int hi_wraps;

  initial begin
    rst = 1'b0; en = 1'b0; up_dn = 1'b1; clr = 1'b0; load = 1'b0;
    d = 4'd0; cmp_val = 4'd6; cen = 1'b0;

    #2;
    chk("reset_q", int'(q), 0);
    chk("reset_wrap", int'(wrap), 0);
    chk("reset_match", int'(match), 0);

    // Up count from reset: 12 clocks.
    @(negedge clk);
    rst = 1'b1;
    en  = 1'b1;
    #1;
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("up_tc[%0d]", i), int'(tc), (i == 9) ? 1 : 0);
      step();
      chk($sformatf("up_q[%0d]", i), int'(q), exp_q[i]);
      chk($sformatf("up_wrap[%0d]", i), int'(wrap), (i == 9) ? 1 : 0);
      chk($sformatf("up_match[%0d]", i), int'(match), (MATCH_ON && i == 6) ? 1 : 0);
    end

    // Clear beats en, then count down through zero.
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr_q", int'(q), 0);
    chk("clr_wrap", int'(wrap), 0);
    up_dn = 1'b0;
    #1;
    chk("dn_tc_at0", int'(tc), 1);
    step();
    chk("dn_q_wrap", int'(q), 9);
    chk("dn_wrap", int'(wrap), 1);
    chk("dn_tc_at9", int'(tc), 0);
    step();
    chk("dn_q_8", int'(q), 8);
    chk("dn_wrap_gone", int'(wrap), 0);

    // Saturating load, then clr outranking load.
    en = 1'b0; load = 1'b1; d = 4'd13;
    step();
    chk("load_sat", int'(q), 9);
    d = 4'd5; clr = 1'b1; en = 1'b1;
    step();
    chk("load_clr_prio", int'(q), 0);
    clr = 1'b0; d = 4'd3; up_dn = 1'b0;
    #1;
    chk("load_tc_raw", int'(tc), 1);
    step();
    chk("load_over_en", int'(q), 3);
    chk("load_no_wrap", int'(wrap), 0);
    load = 1'b0; en = 1'b0;
    step();
    chk("hold", int'(q), 3);

    // Direction change takes effect on the edge it is sampled.
    en = 1'b1; up_dn = 1'b0;
    step();
    chk("dir_dn", int'(q), 2);
    up_dn = 1'b1;
    step();
    chk("dir_up", int'(q), 3);
    chk("dir_no_wrap", int'(wrap), 0);

    // Asynchronous reset mid-count at q=7.
    clr = 1'b1;
    step();
    clr = 1'b0;
    repeat (7) step();
    chk("pre_rst_q", int'(q), 7);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_q", int'(q), 0);
    chk("async_rst_wrap", int'(wrap), 0);
    @(negedge clk);
    rst = 1'b1;
    step();
    chk("resume_q", int'(q), 1);
    chk("resume_wrap", int'(wrap), 0);

    // Two-stage cascade, 100 clocks.
    en = 1'b0;
    chk("casc_start_lo", int'(q_lo), 0);
    chk("casc_start_hi", int'(q_hi), 0);
    cen = 1'b1;
    hi_wraps = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (i == 98) begin
        chk("casc_99_lo", int'(q_lo), 9);
        chk("casc_99_hi", int'(q_hi), 9);
      end
      if (wrap_hi) hi_wraps++;
    end
    chk("casc_lo", int'(q_lo), 0);
    chk("casc_hi", int'(q_hi), 0);
    chk("casc_hi_wraps", hi_wraps, 1);
    cen = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mod_counter.md
MOD_COUNTER -- requirements
Module: mod_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 4, count register width in bits.
REQ-002 SHALL have parameter MODULUS, default 10, count range 0..MODULUS-1.
REQ-003 SHALL have port clk input 1, rising-edge clock.
REQ-004 SHALL have port rst input 1, reset: asynchronous, active-low.
REQ-005 SHALL have port en input 1, count enable (cascade carry-in).
REQ-006 SHALL have port up_dn input 1, 1 = count up, 0 = count down.
REQ-007 SHALL have port clr input 1, synchronous clear to 0.
REQ-008 SHALL have port load input 1, synchronous parallel load.
REQ-009 SHALL have port d input WIDTH, load value.
REQ-010 SHALL have port q output WIDTH, current count.
REQ-011 SHALL have port tc output 1, combinational terminal count (cascade carry-out).
REQ-012 SHALL have port wrap output 1, registered one-cycle wrap pulse.
REQ-013 SHALL have port cmp_val input WIDTH, match compare value.
REQ-014 SHALL have port match output 1, registered compare flag.

Function
REQ-015 SHALL update q only on rising clk; per-cycle priority is clr > load > en > hold.
REQ-016 SHALL, when clr=1, set q=0 and wrap=0 on the next edge, regardless of load/en.
REQ-017 SHALL, when load=1 and clr=0, set q=d if d<MODULUS, else q=MODULUS-1 (saturate); wrap=0.
REQ-018 SHALL, when en=1 with up_dn=1, set q=q+1, or 0 when q=MODULUS-1.
REQ-019 SHALL, when en=1 with up_dn=0, set q=q-1, or MODULUS-1 when q=0.
REQ-020 SHALL hold q when en=0, clr=0 and load=0.
REQ-021 SHALL drive tc=1 iff en=1 and (up_dn=1 and q=MODULUS-1, or up_dn=0 and q=0); zero latency for ripple-enable cascading.
REQ-022 SHALL assert wrap for exactly the one cycle following an edge on which a count wrapped (q went MODULUS-1->0 or 0->MODULUS-1 by counting).
REQ-023 SHALL apply an up_dn change on the same edge it is sampled; no extra step and no wrap unless the boundary rule is met.
REQ-024 SHALL treat MODULUS=2**WIDTH as full binary wrap with no extra compare penalty.
REQ-025 SHALL reject MODULUS<2 or MODULUS>2**WIDTH with an elaboration-time error.

Reset
REQ-026 SHALL, on rst=0, immediately force q=0, wrap=0, match=0, independent of clk.
REQ-027 SHALL resume counting on the first rising clk after rst deasserts; reset asserted mid-count SHALL abort the count with no wrap pulse.

Configuration
REQ-028 SHALL, with macro MOD_COUNTER_MATCH_EN defined, register match=1 on the edge after the one where q becomes equal to cmp_val (i.e. match reflects q==cmp_val one cycle late), else 0.
REQ-029 SHALL, without MOD_COUNTER_MATCH_EN, keep cmp_val and match ports, ignore cmp_val and tie match=0.

Structure
REQ-030 SHALL place the up/down direction constants (DIR_UP=1, DIR_DOWN=0) and the modulus-legality check function in shared package counter_pkg.
REQ-031 SHALL instantiate sub-module dff_bank (WIDTH-wide D register, async active-low reset to 0) for the q state; next-state logic SHALL stay in mod_counter.

Verification
REQ-032 SHALL cover: WIDTH=4, MODULUS=10, en=1, up_dn=1 from reset, 12 clocks -> q 1..9,0,1,2; tc=1 while q=9; wrap=1 cycle after q->0.
REQ-033 SHALL cover: up_dn=0 from q=0, en=1 -> q=9 next edge, tc=1 in the q=0 cycle, wrap pulse follows.
REQ-034 SHALL cover: load=1, d=13 with MODULUS=10 -> q=9; load=1, d=5, clr=1 same cycle -> q=0.
REQ-035 SHALL cover: two instances cascaded (low tc -> high en), both MODULUS=10 -> after 100 clocks q_high=0, q_low=0, high wrap pulses once.
REQ-036 SHALL cover: rst=0 asserted between clocks at q=7 -> q=0 immediately, no wrap; counting resumes at 1 on first clk after release.
REQ-037 SHALL cover: MOD_COUNTER_MATCH_EN defined, cmp_val=6, counting up -> match=1 for one cycle, the cycle after q=6; undefined -> match stays 0.
